// File: rtl/tick_scheduler.sv
// tick_scheduler: prescaled multi-channel timer that shares one valid/ready event port.
// Optional build macro SCHED_FIXED_PRIO_EN selects lowest-index-wins arbitration instead of round-robin.
module tick_scheduler #(
  parameter int NUM_CH        = 4,
  parameter int CH_W          = 2,
  parameter int PERIOD_W      = 16,
  parameter int PRESC_W       = 26,
  parameter int PRESC_DEFAULT = 10000000
) (
  input  logic                clk10,
  input  logic                reset,
  input  logic                prescale_ld,
  input  logic [PRESC_W-1:0]  prescale_in,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cfg_en,
  input  logic                overrun_clr,
  output logic                ev_valid,
  output logic [CH_W-1:0]     ev_ch,
  input  logic                ev_ready,
  output logic                base_tick,
  output logic [NUM_CH-1:0]   overrun
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t              state;
  logic [PRESC_W-1:0]  presc_cnt;
  logic [PRESC_W-1:0]  div_reg;
  logic [PRESC_W-1:0]  div_last;

  logic [PERIOD_W-1:0] ch_cnt    [NUM_CH];
  logic [PERIOD_W-1:0] ch_period [NUM_CH];
  logic [NUM_CH-1:0]   ch_en;
  logic [NUM_CH-1:0]   pending;
  logic [NUM_CH-1:0]   expire;
  logic [NUM_CH-1:0]   granted;
  logic                grant_go;
  logic [CH_W-1:0]     winner;
  logic                found;
`ifndef SCHED_FIXED_PRIO_EN
  logic [CH_W-1:0]     last_grant;
`endif

  // A divide value of zero behaves like one, so the terminal count is zero in both cases.
  assign div_last = (div_reg == '0) ? '0 : div_reg - PRESC_W'(1);

  always_ff @(posedge clk10) begin
    if (!reset) begin
      presc_cnt <= '0;
      div_reg   <= PRESC_W'(PRESC_DEFAULT);
      base_tick <= 1'b0;
    end else if (prescale_ld) begin
      presc_cnt <= '0;
      div_reg   <= prescale_in;
      base_tick <= 1'b0;
    end else if (presc_cnt == div_last) begin
      presc_cnt <= '0;
      base_tick <= 1'b1;
    end else begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
      base_tick <= 1'b0;
    end
  end

  assign grant_go = (state == IDLE) && (|pending);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      expire[c]  = base_tick && ch_en[c] && (ch_period[c] != '0) &&
                   (ch_cnt[c] == ch_period[c] - PERIOD_W'(1));
      granted[c] = grant_go && (winner == CH_W'(c));
    end
  end

`ifdef SCHED_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && pending[i]) begin
        winner = CH_W'(i);
        found  = 1'b1;
      end
    end
  end
`else
  // Search starts just above the previous winner and wraps, so every pending channel is reached.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!found && pending[(int'(last_grant) + i) % NUM_CH]) begin
        winner = CH_W'((int'(last_grant) + i) % NUM_CH);
        found  = 1'b1;
      end
    end
  end
`endif

  // A config write owns the channel that cycle; an expiry racing a grant keeps the event pending.
  always_ff @(posedge clk10) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ch_cnt[c]    <= '0;
        ch_period[c] <= '0;
      end
      ch_en   <= '0;
      pending <= '0;
      overrun <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_we && (cfg_ch == CH_W'(c))) begin
          ch_period[c] <= cfg_period;
          ch_en[c]     <= cfg_en;
          ch_cnt[c]    <= '0;
          pending[c]   <= 1'b0;
          overrun[c]   <= 1'b0;
        end else begin
          if (expire[c])
            ch_cnt[c] <= '0;
          else if (base_tick && ch_en[c] && (ch_period[c] != '0))
            ch_cnt[c] <= ch_cnt[c] + PERIOD_W'(1);

          if (expire[c])
            pending[c] <= 1'b1;
          else if (granted[c])
            pending[c] <= 1'b0;

          if (expire[c] && pending[c] && !granted[c])
            overrun[c] <= 1'b1;
          else if (overrun_clr)
            overrun[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk10) begin
    if (!reset) begin
      state    <= IDLE;
      ev_valid <= 1'b0;
      ev_ch    <= '0;
`ifndef SCHED_FIXED_PRIO_EN
      last_grant <= CH_W'(NUM_CH - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_go) begin
            ev_valid <= 1'b1;
            ev_ch    <= winner;
`ifndef SCHED_FIXED_PRIO_EN
            last_grant <= winner;
`endif
            state    <= OFFER;
          end
        end
        OFFER: begin
          if (ev_ready) begin
            ev_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
Multi-channel tick scheduler built around a programmable clock-enable prescaler running on clk10. Each of NUM_CH channels counts prescaler ticks up to its own programmed period. On expiry a channel raises a pending event. A round-robin arbiter serialises pending events onto a single valid/ready event port, so one downstream datapath is shared between all timed requesters.

Parameters:
NUM_CH, 4, number of timer channels
CH_W, 2, channel index width (clog2 NUM_CH)
PERIOD_W, 16, channel period width, in prescaler ticks
PRESC_W, 26, prescaler divide-value width
PRESC_DEFAULT, 10000000, divide value loaded at reset

Ports:
clk10  in  1  system clock
reset  in  1  synchronous reset, active-low
prescale_ld  in  1  load prescale_in into the divide register
prescale_in  in  PRESC_W  new prescaler divide value
cfg_we  in  1  channel configuration write strobe
cfg_ch  in  CH_W  channel being configured
cfg_period  in  PERIOD_W  channel period
cfg_en  in  1  channel enable
overrun_clr  in  1  clear all overrun bits
ev_valid  out  1  event offered
ev_ch  out  CH_W  channel index of the offered event
ev_ready  in  1  downstream accepts event
base_tick  out  1  one-cycle prescaler tick (observability)
overrun  out  NUM_CH  sticky per-channel overrun flags

Behaviour:
- Reset is sampled only at the clk10 edge. When reset==0:
  - prescaler count = 0; divide register = PRESC_DEFAULT.
  - All channel counts, periods, enables, pending bits and overrun bits = 0.
  - ev_valid = 0, ev_ch = 0, base_tick = 0.
  - last_grant = NUM_CH-1.
  - FSM = IDLE.
  - Reset mid-offer drops the event silently.
- Prescaler:
  - Counts 0..div-1. base_tick is registered and is 1 for exactly one cycle when count == div-1; count then wraps to 0.
  - div == 0 is treated as 1, giving base_tick every cycle.
  - prescale_ld writes the divide register and clears count the same edge. No tick is produced on that edge.
- Channel c:
  - Fires when enabled, period != 0 and base_tick == 1. If cnt == period-1: cnt <= 0 and pending[c] <= 1; otherwise cnt <= cnt+1.
  - period == 0 means the channel never fires.
  - cfg_we for channel c writes period and enable, and clears cnt, pending[c] and overrun[c]. A config write beats a simultaneous expiry on the same channel.
- Overrun:
  - Expiry while pending[c] is already 1 (and not being granted this cycle) sets overrun[c].
  - overrun[c] is sticky. It is cleared by overrun_clr or by a config write to c.
  - If expiry coincides with grant of c, pending stays 1 and no overrun is flagged.
- Arbiter FSM:
  - IDLE: if any pending bit is set, pick the first set bit searching upward from last_grant+1 (wrapping). Then ev_ch <= winner, ev_valid <= 1, pending[winner] <= 0, last_grant <= winner, and go to OFFER.
  - OFFER: ev_valid and ev_ch are held stable until ev_valid & ev_ready. On that edge ev_valid <= 0 and the FSM returns to IDLE.
  - Peak throughput is one event per 2 cycles. Latency from pending set to ev_valid is 1 cycle when in IDLE.
  - A config write to the channel being offered does not retract the offer.

Optional Feature:
SCHED_FIXED_PRIO_EN
- Defined: the arbiter uses fixed priority (lowest index wins) and last_grant is not used.
- Undefined (default): round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then idle 20 cycles -> ev_valid=0, overrun=0, base_tick pulses every PRESC_DEFAULT cycles (use a small-default build override).
- prescale_ld with value 4; ch0 period 3 enabled; ev_ready tied 1 -> base_tick every 4 cycles, ev_valid with ev_ch=0 every 12 cycles.
- div 1; ch0–ch3 all period 1; ev_ready=1 -> grants in order 0,1,2,3,0,…; overrun bits become set because service rate is below the arrival rate.
- ch2 period 2, ev_ready held 0 for 10 ticks -> ev_valid/ev_ch=2 stay stable, overrun[2]=1; overrun_clr -> overrun[2]=0.
- cfg_we to ch1 in the same cycle ch1 expires -> no pending, no event, count restarts from 0.
- Assert reset (0) during OFFER -> next cycle ev_valid=0, all state cleared; SCHED_FIXED_PRIO_EN build with ch0 and ch3 continuously pending -> ch0 always granted.
